// File: rtl/melody_player_if.sv
// melody_player_if: trigger/output bundle between the game controller and
// the melody player.
//   enable      block enable (low = clear to idle)
//   trig_start  one-cycle pulse: play the start jingle (tune 0)
//   trig_over   one-cycle pulse: play the game-over jingle (tune 1)
//   pitch       full-period clock count of the sounding note, 0 = silent
//   tone        square wave for the buzzer
//   busy        a tune is in progress
//   tune_id     tune currently or last selected
//   note_idx    index of the current note
//   done        one-cycle pulse on natural completion of a tune
// Modports: master = controller side, slave = player side.
interface melody_player_if #(
    parameter int PW = 22
);
    logic          enable;
    logic          trig_start;
    logic          trig_over;
    logic [PW-1:0] pitch;
    logic          tone;
    logic          busy;
    logic          tune_id;
    logic [3:0]    note_idx;
    logic          done;

    modport master (
        output enable, trig_start, trig_over,
        input  pitch, tone, busy, tune_id, note_idx, done
    );

    modport slave (
        input  enable, trig_start, trig_over,
        output pitch, tone, busy, tune_id, note_idx, done
    );
endinterface

// File: rtl/melody_player.sv
// melody_player: plays one of two fixed 8-note jingles with per-note
// duration, optional inter-note silence and a square-wave tone generator.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  melody_player_if.slave (enable, triggers in; pitch/tone/status out)
module melody_player #(
    parameter int PW          = 22,
    parameter int TUNE_LEN    = 8,
    parameter int NOTE_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 2500000
) (
    input logic            clk,
    input logic            rst,
    melody_player_if.slave bus
);
    localparam int MAXC = (NOTE_CYCLES > GAP_CYCLES) ? NOTE_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] NOTE_LAST = CW'(NOTE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [3:0]    LAST_IDX  = 4'(TUNE_LEN - 1);

    // Full-period counts at 100 MHz.
    localparam logic [17:0] P_DO = 18'd191571;
    localparam logic [17:0] P_RE = 18'd170648;
    localparam logic [17:0] P_MI = 18'd151515;
    localparam logic [17:0] P_FA = 18'd143266;
    localparam logic [17:0] P_SO = 18'd127551;
    localparam logic [17:0] P_SI = 18'd101215;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    note_idx, idx_n;
    logic          tune_id, tune_n;
    logic          done_r, done_n;
    logic          note_start, finish, go_over, go_start;
    logic [PW-1:0] pitch, half, hcnt;
    logic          tone_r;

    // Indices 8..15 are rests.
    function automatic logic [PW-1:0] note_pitch(input logic tune, input logic [3:0] idx);
        logic [17:0] v;
        v = '0;
        if (!idx[3]) begin
            case ({tune, idx[2:0]})
                4'b0_000, 4'b0_001, 4'b0_010, 4'b0_011, 4'b0_101: v = P_MI;
                4'b0_100:                                         v = P_DO;
                4'b0_110, 4'b0_111:                               v = P_SO;
                4'b1_000:                                         v = P_SI;
                4'b1_001, 4'b1_010, 4'b1_011:                     v = P_FA;
                4'b1_100:                                         v = P_MI;
                4'b1_101:                                         v = P_RE;
                default:                                          v = P_DO;
            endcase
        end
        return PW'(v);
    endfunction

    assign pitch = (state == PLAY) ? note_pitch(tune_id, note_idx) : '0;
    assign half  = pitch >> 1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            note_idx <= '0;
            tune_id  <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            note_idx <= idx_n;
            tune_id  <= tune_n;
            done_r   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt + CW'(1);
        idx_n      = note_idx;
        tune_n     = tune_id;
        done_n     = 1'b0;
        note_start = 1'b0;
        finish     = 1'b0;
        // The game-over jingle outranks the start jingle; start is only
        // blocked while tune 1 is actually playing.
        go_over    = bus.trig_over;
        go_start   = bus.trig_start && !((state != IDLE) && tune_id);

        case (state)
            IDLE: cnt_n = '0;
            PLAY: begin
                if (cnt == NOTE_LAST) begin
                    cnt_n = '0;
                    if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                    end else if (note_idx == LAST_IDX) begin
                        finish = 1'b1;
                    end else begin
                        idx_n      = note_idx + 4'd1;
                        note_start = 1'b1;
                    end
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (note_idx == LAST_IDX) begin
                        finish = 1'b1;
                    end else begin
                        idx_n      = note_idx + 4'd1;
                        state_n    = PLAY;
                        note_start = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (finish) begin
            state_n = IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
        end

        // A (re)start overrides natural completion, so an aborted tune
        // never reports done.
        if (go_over || go_start) begin
            state_n    = PLAY;
            tune_n     = go_over;
            idx_n      = '0;
            cnt_n      = '0;
            done_n     = 1'b0;
            note_start = 1'b1;
        end

        if (!bus.enable) begin
            state_n    = IDLE;
            tune_n     = 1'b0;
            idx_n      = '0;
            cnt_n      = '0;
            done_n     = 1'b0;
            note_start = 1'b0;
        end
    end

    // Half-period counter: toggles tone every (pitch>>1) cycles, restarting
    // in phase at each note start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt   <= '0;
            tone_r <= 1'b0;
        end else if (note_start || !bus.enable || pitch == '0) begin
            hcnt   <= '0;
            tone_r <= 1'b0;
        end else if (hcnt == half - PW'(1)) begin
            hcnt   <= '0;
            tone_r <= ~tone_r;
        end else begin
            hcnt   <= hcnt + PW'(1);
        end
    end

    // Gating keeps tone low in the cycle pitch drops to 0, before the
    // generator registers have cleared.
    assign bus.pitch    = pitch;
    assign bus.tone     = tone_r & (pitch != '0);
    assign bus.busy     = (state != IDLE);
    assign bus.tune_id  = tune_id;
    assign bus.note_idx = note_idx;
    assign bus.done     = done_r;
endmodule

// File: tb/tb_melody_player.sv
// tb_melody_player: four melody_player instances with different timing
// parameters, a cycle-level reference model of the tune schedule, and
// directed scenarios with hand-computed checkpoints.
module tb_melody_player;
    localparam int NCA [4] = '{4, 4, 4, 200000};
    localparam int GCA [4] = '{2, 0, 0, 0};
    localparam int TLA [4] = '{8, 10, 3, 8};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  en, ts, to;
    logic [21:0] pit [4];
    logic        ton [4];
    logic        bsy [4];
    logic        tid [4];
    logic [3:0]  nid [4];
    logic        dn  [4];

    for (genvar k = 0; k < 4; k++) begin : g
        melody_player_if #(.PW(22)) b ();
        assign b.enable     = en[k];
        assign b.trig_start = ts[k];
        assign b.trig_over  = to[k];
        assign pit[k] = b.pitch;
        assign ton[k] = b.tone;
        assign bsy[k] = b.busy;
        assign tid[k] = b.tune_id;
        assign nid[k] = b.note_idx;
        assign dn[k]  = b.done;
        melody_player #(.PW(22), .TUNE_LEN(TLA[k]), .NOTE_CYCLES(NCA[k]),
                        .GAP_CYCLES(GCA[k])) u (.clk(clk), .rst(rst), .bus(b));
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint got, input longint want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, want, want);
        end
    endtask

    // ---------------- reference model ----------------
    // Each tune is a timeline: elapsed cycles e since the start edge, split
    // into slots of NOTE+GAP cycles; slot n plays note n for NOTE cycles.
    int T0 [8] = '{151515, 151515, 151515, 151515, 191571, 151515, 127551, 127551};
    int T1 [8] = '{101215, 143266, 143266, 143266, 151515, 170648, 191571, 191571};

    bit m_act [4], m_tune [4], m_tid [4], m_done [4];
    int m_e [4];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 4; k++) begin
            if (rst || !en[k]) begin
                m_act[k] <= 0; m_tune[k] <= 0; m_tid[k] <= 0; m_done[k] <= 0; m_e[k] <= 0;
            end else if (to[k] || (ts[k] && !(m_act[k] && m_tune[k]))) begin
                m_act[k] <= 1; m_tune[k] <= to[k]; m_tid[k] <= to[k]; m_done[k] <= 0; m_e[k] <= 0;
            end else if (m_act[k] && m_e[k] + 1 == TLA[k] * (NCA[k] + GCA[k])) begin
                m_act[k] <= 0; m_done[k] <= 1; m_e[k] <= 0;
            end else begin
                m_done[k] <= 0;
                if (m_act[k]) m_e[k] <= m_e[k] + 1;
            end
        end
    end

    function automatic int exp_pitch(int k);
        int slot, n;
        slot = NCA[k] + GCA[k];
        n = m_e[k] / slot;
        if (!m_act[k] || (m_e[k] % slot) >= NCA[k] || n >= 8) return 0;
        return m_tune[k] ? T1[n] : T0[n];
    endfunction

    function automatic logic [29:0] exp_vec(int k);
        int p, w, tn, ix;
        p  = exp_pitch(k);
        w  = m_e[k] % (NCA[k] + GCA[k]);
        tn = (p == 0) ? 0 : (w / (p / 2)) % 2;
        ix = m_act[k] ? m_e[k] / (NCA[k] + GCA[k]) : 0;
        return {22'(p), 1'(tn), 1'(m_act[k]), 1'(m_tid[k]), 4'(ix), 1'(m_done[k])};
    endfunction

    always @(negedge clk) begin
        if (n_bad < 100) begin
            for (int k = 0; k < 4; k++)
                chk($sformatf("dut%0d outputs {pitch,tone,busy,tune,idx,done}", k),
                    {pit[k], ton[k], bsy[k], tid[k], nid[k], dn[k]}, exp_vec(k));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic pulse(input int k, input bit s, input bit o);
        @(posedge clk); #1;
        ts[k] = s; to[k] = o;
        @(posedge clk); #1;
        ts[k] = 0; to[k] = 0;
    endtask

    int S1 [8] = '{101215, 143266, 143266, 143266, 151515, 170648, 191571, 191571};
    int rise_c, ndone;

    initial begin
        en = 4'hF; ts = '0; to = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset pitch", pit[0], 0);
        chk("reset busy", bsy[0], 0);
        chk("reset tone", ton[0], 0);
        #2 rst = 0;

        // 1: game-over jingle with gaps
        pulse(0, 0, 1);
        for (int c = 0; c <= 48; c++) begin
            @(negedge clk);
            if (c < 48 && c % 6 == 0) chk($sformatf("t1 pitch c%0d", c), pit[0], S1[c / 6]);
            if (c == 4) chk("t1 gap pitch", pit[0], 0);
            if (c == 47) chk("t1 busy before end", bsy[0], 1);
            if (c == 48) begin
                chk("t1 done", dn[0], 1);
                chk("t1 busy at done", bsy[0], 0);
            end
        end

        // 2: tone half-period on a long note
        pulse(3, 1, 0);
        rise_c = -1;
        for (int c = 0; c < 75800; c++) begin
            @(negedge clk);
            if (ton[3] && rise_c < 0) rise_c = c;
        end
        chk("t2 first tone rise", rise_c, 75757);
        en[3] = 0;
        repeat (3) @(posedge clk); #1;
        en[3] = 1;

        // 3: trig_over pre-empts tune 0 at note 3
        pulse(0, 1, 0);
        repeat (19) @(posedge clk); #1;
        to[0] = 1;
        @(posedge clk); #1;
        to[0] = 0;
        @(negedge clk);
        chk("t3 tune_id", tid[0], 1);
        chk("t3 note_idx", nid[0], 0);
        chk("t3 pitch", pit[0], 101215);
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ndone += dn[0];
        end
        chk("t3 done count", ndone, 1);

        // 4: simultaneous triggers, then ignored trig_start
        pulse(0, 1, 1);
        @(negedge clk);
        chk("t4 tune_id", tid[0], 1);
        repeat (7) @(posedge clk); #1;
        ts[0] = 1;
        @(posedge clk); #1;
        ts[0] = 0;
        @(negedge clk);
        chk("t4 pitch kept", pit[0], 143266);
        chk("t4 idx kept", nid[0], 1);
        repeat (50) @(posedge clk);

        // 5: TUNE_LEN 10 with rests, and TUNE_LEN 3
        pulse(1, 1, 0);
        for (int c = 0; c <= 40; c++) begin
            @(negedge clk);
            if (c == 32) begin
                chk("t5 rest pitch", pit[1], 0);
                chk("t5 rest busy", bsy[1], 1);
                chk("t5 rest idx", nid[1], 8);
            end
            if (c == 37) chk("t5 idx9", nid[1], 9);
            if (c == 40) chk("t5 done", dn[1], 1);
        end
        pulse(2, 1, 0);
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            if (c == 8) chk("t5b note2 pitch", pit[2], 151515);
            if (c == 12) chk("t5b done", dn[2], 1);
        end

        // 6: reset and enable drop mid-tune
        pulse(0, 1, 0);
        repeat (5) @(posedge clk); #2;
        rst = 1;
        #1;
        chk("t6 rst pitch", pit[0], 0);
        chk("t6 rst busy", bsy[0], 0);
        @(negedge clk);
        rst = 0;
        pulse(0, 1, 0);
        repeat (5) @(posedge clk); #1;
        en[0] = 0;
        @(negedge clk);
        chk("t6 busy before enable edge", bsy[0], 1);
        @(negedge clk);
        chk("t6 en busy", bsy[0], 0);
        chk("t6 en pitch", pit[0], 0);
        ndone = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            ndone += dn[0];
        end
        chk("t6 no done", ndone, 0);
        en[0] = 1;
        pulse(0, 1, 0);
        @(negedge clk);
        chk("t6 restart pitch", pit[0], 151515);
        chk("t6 restart busy", bsy[0], 1);
        repeat (50) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/melody_player.md
Name: melody_player

Overview:
- Parametrised successor to the game sound sequencer.
- Plays one of two fixed 8-note tunes on request: tune 0 is the start jingle, tune 1 is the game-over jingle.
- Adds per-note duration timing, inter-note silence, pre-emption priority and an on-chip square-wave tone generator, in place of a bare pitch index.
- Sits between the game control FSM (trigger pulses) and the buzzer pin.

Parameters:
- PW, 22, width of the pitch (full-period clock count) bus.
- TUNE_LEN, 8, notes per tune; range 1..16. Index i >= 8 plays a rest. TUNE_LEN < 8 truncates the tune.
- NOTE_CYCLES, 25000000, cycles each note sounds; must be >= 1.
- GAP_CYCLES, 2500000, silent cycles after each note; 0 means no gap state.

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  block enable. Low = synchronous clear to IDLE; triggers ignored.
- trig_start  in  1  one-cycle pulse: play tune 0.
- trig_over  in  1  one-cycle pulse: play tune 1.
- pitch  out  PW  full-period count of the current note; 0 = rest or idle.
- tone  out  1  square wave to buzzer.
- busy  out  1  tune in progress.
- tune_id  out  1  tune currently or last selected.
- note_idx  out  4  index of current note.
- done  out  1  one-cycle pulse at natural tune completion.

Behaviour:
- Reset (rst, or enable low at a clock edge): all outputs 0; state = IDLE; all counters 0.
- Pitch constants:
  - do = 191571, re = 170648, mi = 151515, fa = 143266
  - so = 127551, la = 113636, si = 101215, hdo = 95420
- Tune contents:
  - Tune 0: mi mi mi mi do mi so so.
  - Tune 1: si fa fa fa mi re do do.
- FSM states: IDLE, PLAY, GAP.
- IDLE -> PLAY on a trigger sampled at edge t:
  - From t+1: busy=1, note_idx=0, pitch = note 0 of the selected tune, tone=0, duration counter cleared.
- PLAY:
  - pitch holds the note value for exactly NOTE_CYCLES cycles.
  - Then -> GAP if GAP_CYCLES > 0. Otherwise go straight to the next note, or finish if this was the last note.
- GAP:
  - pitch = 0, tone = 0 for exactly GAP_CYCLES cycles.
  - Then note_idx++ and -> PLAY, or finish if note_idx == TUNE_LEN-1.
- Finish: done=1 for one cycle, in the first cycle after the final note/gap. In that same cycle busy=0, pitch=0, note_idx=0, and state -> IDLE.
- tune_id holds its value after finishing.
- Tone generator:
  - Half-period counter resets to 0 and tone to 0 at every note start.
  - Counter increments each cycle while pitch != 0.
  - When counter == (pitch>>1)-1, tone toggles and the counter clears.
  - Result: tone period = 2*(pitch>>1) cycles.
  - pitch == 0 holds tone at 0.
- Priority and pre-emption:
  - trig_over and trig_start on the same edge: tune 1 wins.
  - trig_over during tune 0: abort and restart as tune 1 at note 0. No done pulse for the aborted tune.
  - trig_start during tune 1: ignored.
  - Re-trigger of the playing tune: restart at note 0, duration and tone counters cleared.
- A trigger in the same cycle done is asserted starts a new tune normally at the next edge.
- Duration counter width: $clog2(max(NOTE_CYCLES, GAP_CYCLES)+1). No wrap inside a note.

Test Plan:
1. NOTE_CYCLES=4, GAP_CYCLES=2; pulse trig_over.
   - pitch sequence, each value 4 cycles separated by 2 cycles of 0: 101215, 143266, 143266, 143266, 151515, 170648, 191571, 191571.
   - done pulses 48 cycles after the trigger edge; busy=0 in the same cycle.
2. NOTE_CYCLES=200000, GAP_CYCLES=0; pulse trig_start.
   - During note 0, tone toggles every 75757 cycles (mi = 151515).
   - First rising edge of tone 75757 cycles after note start.
3. NOTE_CYCLES=4, GAP_CYCLES=2; trig_start, then trig_over at note 3.
   - Next cycle: tune_id=1, note_idx=0, pitch=101215.
   - No done for tune 0; a single done at the end of tune 1.
4. Same params; trig_start and trig_over on the same edge.
   - tune_id=1.
   - A later trig_start mid-tune leaves pitch/note_idx unchanged.
5. TUNE_LEN=10, GAP_CYCLES=0.
   - Notes 8 and 9 give pitch=0 and tone=0 for 4 cycles each.
   - done 40 cycles after the trigger.
   - TUNE_LEN=3 plays 3 notes only.
6. Assert rst mid-note, or drop enable mid-tune.
   - All outputs 0 immediately (rst) or next edge (enable).
   - No done pulse; a trigger applied after release plays normally.
